max_finder: RTL and testbench

Tracking-side peak locator that closes the loop on the box tracker. It consumes the per-pixel template-match score stream, searches a window around the last reported position, and picks the best-scoring pixel. At end of frame it publishes `max_x`, `max_y` and a one-cycle `max_ready` strobe, which drive the box centre in tracking mode. It sits between the match-score datapath and the box logic.

---
 rtl/max_finder.sv | 158 +++++++++++++++
 tb/tb_max_finder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max_finder.sv
// -----------------------------------------------------------------------------
// max_finder
//   Peak locator for the box tracker. Scans the per-pixel match-score stream of
//   one frame, keeps the best-scoring pixel inside a square window around the
//   last reported position, and publishes it at end of frame with a one-cycle
//   max_ready strobe. If the previous frame found nothing (lost=1), the next
//   frame is searched without the window so the target can be reacquired.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   track_en              tracking enable; low holds in IDLE or aborts a search
//   frame_start           one-cycle pulse, start of a frame's score stream
//   frame_end             one-cycle pulse on the last scored pixel
//   score_valid           score / score_x / score_y valid this cycle
//   score                 unsigned match score, higher is better
//   score_x, score_y      pixel coordinates of score
//   max_x, max_y          reported peak position, held between reports
//   max_score             score at the reported peak (0 when lost)
//   max_ready             one-cycle strobe: new report on the outputs
//   lost                  last frame had no valid candidate
// -----------------------------------------------------------------------------
module max_finder #(
  parameter int unsigned        SCORE_W       = 16,
  parameter logic [SCORE_W-1:0] MIN_SCORE     = SCORE_W'(32),
  parameter logic [9:0]         SEARCH_RADIUS = 10'd64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               track_en,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         score_x,
  input  logic [9:0]         score_y,
  output logic [9:0]         max_x,
  output logic [9:0]         max_y,
  output logic [SCORE_W-1:0] max_score,
  output logic               max_ready,
  output logic               lost
);

  localparam logic [9:0] RST_X = 10'd320;
  localparam logic [9:0] RST_Y = 10'd240;

  typedef enum logic [1:0] {IDLE, SEARCH, REPORT} state_t;

  state_t             state_q;
  logic [9:0]         cx_q, cy_q;
  logic               reacq_q;
  logic               best_valid_q, best_valid_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [9:0]         best_x_q, best_x_d;
  logic [9:0]         best_y_q, best_y_d;
  logic [9:0]         max_x_q, max_y_q;
  logic [SCORE_W-1:0] max_score_q;
  logic               max_ready_q;
  logic               lost_q;
  logic               in_win;
  logic               cand;
  logic               arm;

  // Distance between two screen coordinates, computed in 11-bit signed so a
  // window hanging off the screen edge never wraps around.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? $unsigned(-d) : $unsigned(d);
  endfunction

  // Candidate test is combinational on the inputs, so a sample arriving with
  // frame_end is folded into the report on the same edge.
  always_comb begin
    in_win = reacq_q ||
             ((abs_diff(score_x, cx_q) <= {1'b0, SEARCH_RADIUS}) &&
              (abs_diff(score_y, cy_q) <= {1'b0, SEARCH_RADIUS}));
    // Strict greater-than: on a tie the earlier sample in raster order stays.
    cand = (state_q == SEARCH) && score_valid && (score >= MIN_SCORE) && in_win &&
           (!best_valid_q || (score > best_score_q));
    best_valid_d = best_valid_q | cand;
    best_score_d = cand ? score   : best_score_q;
    best_x_d     = cand ? score_x : best_x_q;
    best_y_d     = cand ? score_y : best_y_q;
    // A new search is armed the same way from every state: from IDLE, as a
    // restart inside SEARCH, or back-to-back out of REPORT.
    arm = frame_start && track_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cx_q         <= RST_X;
      cy_q         <= RST_Y;
      reacq_q      <= 1'b0;
      best_valid_q <= 1'b0;
      best_score_q <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      max_x_q      <= RST_X;
      max_y_q      <= RST_Y;
      max_score_q  <= '0;
      max_ready_q  <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      max_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arm) state_q <= SEARCH;
        end
        SEARCH: begin
          if (!track_en) begin
            // Abort: drop the partial result, leave the published report alone.
            state_q <= IDLE;
          end else if (!frame_start) begin
            best_valid_q <= best_valid_d;
            best_score_q <= best_score_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
            if (frame_end) begin
              state_q     <= REPORT;
              max_ready_q <= 1'b1;
              if (best_valid_d) begin
                max_x_q     <= best_x_d;
                max_y_q     <= best_y_d;
                max_score_q <= best_score_d;
                lost_q      <= 1'b0;
              end else begin
                max_score_q <= '0;
                lost_q      <= 1'b1;
              end
            end
          end
        end
        REPORT: begin
          state_q <= arm ? SEARCH : IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Entering SEARCH: clear the running best and centre the window on the
      // currently published position. Out of REPORT this is the fresh report.
      if (arm) begin
        best_valid_q <= 1'b0;
        best_score_q <= '0;
        cx_q         <= max_x_q;
        cy_q         <= max_y_q;
        reacq_q      <= lost_q;
      end
    end
  end

  assign max_x     = max_x_q;
  assign max_y     = max_y_q;
  assign max_score = max_score_q;
  assign max_ready = max_ready_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_max_finder.sv
// -----------------------------------------------------------------------------
// tb_max_finder
//   Directed and randomized frames for max_finder. Expected reports come from a
//   frame-level model: filter the frame to eligible samples, take the largest
//   score, earliest occurrence wins.
// -----------------------------------------------------------------------------
module tb_max_finder;

  localparam int MIN_S  = 32;
  localparam int RADIUS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        track_en;
  logic        frame_start;
  logic        frame_end;
  logic        score_valid;
  logic [15:0] score;
  logic [9:0]  score_x;
  logic [9:0]  score_y;
  logic [9:0]  max_x;
  logic [9:0]  max_y;
  logic [15:0] max_score;
  logic        max_ready;
  logic        lost;

  int errors = 0;
  int checks = 0;
  int ready_cnt = 0;

  int qx[$];
  int qy[$];
  int qs[$];

  int m_x = 320;
  int m_y = 240;
  int m_s = 0;
  bit m_lost = 1'b0;

  max_finder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .track_en    (track_en),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .score_valid (score_valid),
    .score       (score),
    .score_x     (score_x),
    .score_y     (score_y),
    .max_x       (max_x),
    .max_y       (max_y),
    .max_score   (max_score),
    .max_ready   (max_ready),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (max_ready === 1'b1) ready_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, " max_x"},     32'(max_x),     32'(m_x));
    chk({tag, " max_y"},     32'(max_y),     32'(m_y));
    chk({tag, " max_score"}, 32'(max_score), 32'(m_s));
    chk({tag, " lost"},      32'(lost),      32'(m_lost));
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic clr();
    qx.delete(); qy.delete(); qs.delete();
  endtask

  task automatic add(input int x, input int y, input int s);
    qx.push_back(x); qy.push_back(y); qs.push_back(s);
  endtask

  // Frame-level reference: the samples from index 'from' onward are searched.
  task automatic model_frame(input int from);
    int cx, cy, top, idx;
    bit reacq;
    int elig[$];
    cx = m_x; cy = m_y; reacq = m_lost;
    for (int i = from; i < qs.size(); i++)
      if (qs[i] >= MIN_S &&
          (reacq || (iabs(qx[i] - cx) <= RADIUS && iabs(qy[i] - cy) <= RADIUS)))
        elig.push_back(i);
    if (elig.size() == 0) begin
      m_s = 0; m_lost = 1'b1;
    end else begin
      top = -1;
      foreach (elig[k]) if (qs[elig[k]] > top) top = qs[elig[k]];
      idx = -1;
      foreach (elig[k]) if (idx < 0 && qs[elig[k]] == top) idx = elig[k];
      m_x = qx[idx]; m_y = qy[idx]; m_s = top; m_lost = 1'b0;
    end
  endtask

  // Plays the queued frame; restart_at >= 0 inserts a mid-frame frame_start
  // just before that sample.
  task automatic run_frame(input string tag, input int restart_at);
    int rc0;
    model_frame((restart_at < 0) ? 0 : restart_at);
    rc0 = ready_cnt;
    @(negedge clk); track_en = 1'b1; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < qs.size(); i++) begin
      if (i == restart_at) begin
        score_valid = 1'b0; frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
      end
      score_valid = 1'b1;
      score       = 16'(qs[i]);
      score_x     = 10'(qx[i]);
      score_y     = 10'(qy[i]);
      frame_end   = (i == qs.size() - 1);
      @(negedge clk);
    end
    score_valid = 1'b0; frame_end = 1'b0;
    chk({tag, " max_ready"}, 32'(max_ready), 32'd1);
    chk_outputs(tag);
    @(negedge clk);
    chk({tag, " max_ready_drop"}, 32'(max_ready), 32'd0);
    chk({tag, " pulses"}, 32'(ready_cnt - rc0), 32'd1);
  endtask

  initial begin
    int rc0, x, y;
    rst_n = 1'b0; track_en = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    score_valid = 1'b0; score = '0; score_x = '0; score_y = '0;

    repeat (2) @(negedge clk);
    chk("reset max_ready", 32'(max_ready), 32'd0);
    chk_outputs("reset");
    rst_n = 1'b1;

    // Out of reset, stray samples and frame_end without frame_start do nothing.
    rc0 = ready_cnt;
    @(negedge clk); track_en = 1'b1; score_valid = 1'b1; score = 16'd900;
    score_x = 10'd320; score_y = 10'd240; frame_end = 1'b1;
    @(negedge clk); score_valid = 1'b0; frame_end = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle pulses", 32'(ready_cnt - rc0), 32'd0);
    chk_outputs("idle");

    // Single peak: expected (330,250) score 100.
    clr();
    for (int i = 325; i <= 335; i++) add(i, 250, (i == 330) ? 100 : 10);
    run_frame("single", -1);

    // Tie: the first 200 in raster order wins -> (300,230).
    clr(); add(300, 230, 200); add(305, 230, 20); add(310, 230, 200);
    run_frame("tie", -1);

    // Recentre on (320,240), then window test -> (321,240) score 50.
    clr(); add(320, 240, 40);
    run_frame("recentre", -1);
    clr(); add(500, 240, 500); add(321, 240, 50);
    run_frame("window", -1);

    // Lost: all scores below 32, position held, score 0.
    clr(); add(321, 240, 31); add(322, 240, 5); add(330, 241, 0);
    run_frame("lost", -1);
    // Reacquire outside the old window -> (600,400).
    clr(); add(600, 400, 90); add(321, 240, 20);
    run_frame("reacquire", -1);

    // Park the centre at (10,10) via lost + reacquire.
    clr(); add(600, 400, 3);
    run_frame("lost2", -1);
    clr(); add(10, 10, 60);
    run_frame("reacq2", -1);
    // Edge: (0,0) in window without wrap; (75,10) is 65 away and excluded.
    clr(); add(0, 0, 60); add(75, 10, 100); add(200, 200, 100);
    run_frame("edge", -1);
    // Window boundary around (0,0): 64 in, 65 out.
    clr(); add(64, 64, 70); add(65, 0, 80); add(0, 65, 80);
    run_frame("boundary", -1);

    // Randomized frames around the current centre.
    for (int f = 0; f < 6; f++) begin
      clr();
      for (int k = 0; k < 30; k++) begin
        x = m_x + int'($urandom_range(0, 140)) - 70;
        y = m_y + int'($urandom_range(0, 140)) - 70;
        x = (x < 0) ? 0 : ((x > 639) ? 639 : x);
        y = (y < 0) ? 0 : ((y > 479) ? 479 : y);
        add(x, y, int'($urandom_range(0, 60)));
      end
      run_frame($sformatf("rand%0d", f), -1);
    end

    // Final sample arriving with frame_end wins.
    clr(); add(100, 100, 40);
    run_frame("setcentre", -1);
    clr(); add(100, 100, 100); add(100, 101, 150);
    run_frame("last_wins", -1);

    // Restart mid-SEARCH: the 1000 before the restart is discarded.
    clr(); add(m_x, m_y, 1000); add(m_x + 1, m_y, 50); add(m_x + 2, m_y, 80);
    run_frame("restart", 1);

    // Abort: track_en dropped mid-SEARCH.
    rc0 = ready_cnt;
    @(negedge clk); track_en = 1'b1; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0; score_valid = 1'b1; score = 16'd1000;
    score_x = 10'(m_x + 1); score_y = 10'(m_y);
    @(negedge clk); score_valid = 1'b0; track_en = 1'b0;
    @(negedge clk); frame_end = 1'b1; score_valid = 1'b1;
    @(negedge clk); frame_end = 1'b0; score_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort pulses", 32'(ready_cnt - rc0), 32'd0);
    chk_outputs("abort");
    track_en = 1'b1; frame_end = 1'b1;
    @(negedge clk); frame_end = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort idle pulses", 32'(ready_cnt - rc0), 32'd0);

    // Asynchronous reset mid-frame.
    rc0 = ready_cnt;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0; score_valid = 1'b1; score = 16'd500;
    score_x = 10'(m_x); score_y = 10'(m_y);
    @(negedge clk); frame_end = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    m_x = 320; m_y = 240; m_s = 0; m_lost = 1'b0;
    chk("midreset max_ready", 32'(max_ready), 32'd0);
    chk_outputs("midreset");
    @(negedge clk); frame_end = 1'b0; score_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); score_valid = 1'b1; score = 16'd700; frame_end = 1'b1;
    @(negedge clk); score_valid = 1'b0; frame_end = 1'b0;
    repeat (2) @(negedge clk);
    chk("postreset pulses", 32'(ready_cnt - rc0), 32'd0);
    chk_outputs("postreset");
    clr(); add(330, 250, 100); add(331, 250, 10);
    run_frame("afterreset", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
